// File: rtl/argmax_arbiter_if.sv
// argmax_arbiter_if: requester and engine bundle for argmax_arbiter.
// master = requesters/engine side, slave = arbiter side.
interface argmax_arbiter_if #(
  parameter int data_width    = 16,
  parameter int no_inputs     = 10,
  parameter int no_requesters = 4
);
  localparam int VW = data_width * no_inputs;

  logic [no_requesters-1:0]    req;
  logic [no_requesters*VW-1:0] req_data;
  logic [no_requesters-1:0]    ack;
  logic [31:0]                 result;
  logic                        error;
  logic                        busy;
  logic                        eng_valid_input;
  logic [VW-1:0]               eng_data;
  logic                        eng_valid_output;
  logic [31:0]                 eng_data_out;

  modport master (
    output req, req_data,
    output eng_valid_output, eng_data_out,
    input  ack, result, error, busy,
    input  eng_valid_input, eng_data
  );

  modport slave (
    input  req, req_data,
    input  eng_valid_output, eng_data_out,
    output ack, result, error, busy,
    output eng_valid_input, eng_data
  );
endinterface

// File: rtl/argmax_arbiter.sv
// argmax_arbiter: round-robin share of one argmax engine.
// Ports: clk, rst (async, active low), bus (slave modport).
module argmax_arbiter #(
  parameter int data_width    = 16,
  parameter int no_inputs     = 10,
  parameter int no_requesters = 4,
  parameter int timeout       = 64
) (
  input logic             clk,
  input logic             rst,
  argmax_arbiter_if.slave bus
);
  localparam int VW = data_width * no_inputs;
  localparam int IW =
    (no_requesters > 1) ? $clog2(no_requesters) : 1;
  localparam int CW = $clog2(timeout + 1);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     result_q, result_d;
  logic            err_q, err_d;
  logic [VW-1:0]   data_q, data_d;
  logic            found;
  logic [IW-1:0]   pick;
  logic [VW-1:0]   pick_data;
  logic [no_requesters-1:0] ack_d;
  int              rr_idx;

  // Search starts one past the last served requester.
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    rr_idx = 0;
    for (int i = 1; i <= no_requesters; i++) begin
      rr_idx = int'(ptr_q) + i;
      if (rr_idx >= no_requesters)
        rr_idx = rr_idx - no_requesters;
      if (!found && bus.req[IW'(rr_idx)]) begin
        found = 1'b1;
        pick  = IW'(rr_idx);
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < no_requesters; i++)
      if (pick == IW'(i))
        pick_data = bus.req_data[i*VW +: VW];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = pick;
          data_d  = pick_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A done pulse on the last wait cycle still wins.
        if (bus.eng_valid_output) begin
          result_d = bus.eng_data_out;
          err_d    = bus.eng_data_out >= 32'(no_inputs);
          state_d  = RESP;
        end else if (cnt_q == CW'(timeout - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= IW'(no_requesters - 1);
      gnt_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    ack_d = '0;
    for (int i = 0; i < no_requesters; i++)
      ack_d[i] = (state_q == RESP) && (gnt_q == IW'(i));
  end

  assign bus.ack             = ack_d;
  assign bus.result          = result_q;
  assign bus.error           = err_q;
  assign bus.busy            = state_q != IDLE;
  assign bus.eng_valid_input = state_q == ISSUE;
  assign bus.eng_data        = data_q;
endmodule

// File: tb/tb_argmax_arbiter.sv
// tb_argmax_arbiter: random and directed check of argmax_arbiter
// against a transaction-level round-robin model.
module tb_argmax_arbiter;
  localparam int DW = 16;
  localparam int NI = 10;
  localparam int NR = 4;
  localparam int TO = 64;
  localparam int VW = DW * NI;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  argmax_arbiter_if #(
    .data_width(DW), .no_inputs(NI), .no_requesters(NR)
  ) bus ();

  argmax_arbiter #(
    .data_width(DW), .no_inputs(NI),
    .no_requesters(NR), .timeout(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          ptr_m;
  logic [31:0] prev_res;
  logic        prev_err;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference arbitration: first requester after the last one served.
  function automatic int rr(input logic [NR-1:0] r, input int p);
    for (int k = 1; k <= NR; k++)
      if (r[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < NR * VW / 32; i++)
      bus.req_data[i*32 +: 32] = $urandom;
  endtask

  // lat: WAIT cycle (1-based) carrying the done pulse; > TO = silent.
  task automatic txn(input logic [NR-1:0] r, input int lat,
                     input logic [31:0] val, input bit drop);
    int g, n, k, exp_k;
    bit got;
    logic [VW-1:0] exp_d;
    logic [31:0]   exp_r;
    logic          exp_e;
    g = rr(r, ptr_m);
    @(posedge clk); #1;
    bus.req = r;
    rand_data();
    exp_d = VW'(bus.req_data >> (g * VW));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (drop) bus.req = '0;
      @(negedge clk);
    end while (!bus.eng_valid_input && n < 8);
    chk("issue_lat", n, 1);
    chk("eng_data", bus.eng_data, exp_d);
    chk("res_hold", {bus.error, bus.result}, {prev_err, prev_res});
    if (lat >= 1 && lat <= TO) begin
      exp_r = val;
      exp_e = val >= NI;
      exp_k = lat + 1;
    end else begin
      exp_r = '0;
      exp_e = 1'b1;
      exp_k = TO + 1;
    end
    k   = 0;
    got = 1'b0;
    while (!got && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (k == 2) rand_data();
      bus.eng_valid_output = (k == lat);
      bus.eng_data_out     = val;
      @(negedge clk);
      if (k == 1) chk("issue_pulse", bus.eng_valid_input, 0);
      got = bus.ack != '0;
    end
    bus.eng_valid_output = 1'b0;
    chk("ack_seen", got, 1);
    chk("ack_cyc", k, exp_k);
    chk("ack_vec", bus.ack, 1 << g);
    chk("result", bus.result, exp_r);
    chk("error", bus.error, exp_e);
    chk("busy", bus.busy, 1);
    chk("data_stable", bus.eng_data, exp_d);
    ptr_m    = g;
    prev_res = exp_r;
    prev_err = exp_e;
  endtask

  task automatic spurious_done();
    @(posedge clk); #1;
    bus.req              = '0;
    bus.eng_valid_output = 1'b1;
    bus.eng_data_out     = 32'd5;
    @(negedge clk);
    chk("spur_busy", bus.busy, 0);
    @(posedge clk); #1;
    bus.eng_valid_output = 1'b0;
    @(negedge clk);
    chk("spur_idle", {bus.busy, bus.ack}, 0);
    chk("spur_res", {bus.error, bus.result}, {prev_err, prev_res});
  endtask

  task automatic reset_mid_wait();
    @(posedge clk); #1;
    bus.req = 4'b0100;
    rand_data();
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_ack", bus.ack, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_evi", bus.eng_valid_input, 0);
    chk("rst_edata", bus.eng_data, 0);
    chk("rst_res", {bus.error, bus.result}, 0);
    @(posedge clk); #1;
    rst     = 1'b1;
    bus.req = '0;
    ptr_m    = NR - 1;
    prev_res = '0;
    prev_err = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("rst_noack", {bus.busy, bus.ack}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, sel;
    bus.req              = '0;
    bus.req_data         = '0;
    bus.eng_valid_output = 1'b0;
    bus.eng_data_out     = '0;
    ptr_m    = NR - 1;
    prev_res = '0;
    prev_err = 1'b0;
    #12;
    chk("init_ack", bus.ack, 0);
    chk("init_busy", bus.busy, 0);
    chk("init_evi", bus.eng_valid_input, 0);
    chk("init_res", {bus.error, bus.result}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    repeat (5) txn(4'b1111, 3, 32'd2, 1'b0);
    txn(4'b0001, 11, 32'd0, 1'b0);
    txn(4'b0010, 70, 32'd9, 1'b0);
    txn(4'b0100, 3, 32'd12, 1'b0);
    txn(4'b1000, 64, 32'd4, 1'b0);
    txn(4'b0001, 1, 32'd7, 1'b1);
    spurious_done();
    txn(4'b0010, 2, 32'd7, 1'b0);
    reset_mid_wait();
    txn(4'b1001, 5, 32'd2, 1'b0);

    for (int t = 0; t < 25; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      lat = 70;
      else if (sel == 1) lat = 64;
      else               lat = $urandom_range(1, 20);
      txn(4'($urandom_range(1, 15)), lat,
          32'($urandom_range(0, 13)),
          1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
